// File: rtl/ltssm_ts_rx_tracker.sv
// ltssm_ts_rx_tracker: per-lane TS1/TS2/idle run counting and link qualification flags
module ltssm_ts_rx_tracker #(
   parameter int MAX_NUM_LANES = 4,
   parameter int TS_COUNT_TARGET = 8,
   parameter int IDLE_COUNT_TARGET = 8,
   parameter logic [7:0] PAD_SYMBOL = 8'hF7
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic [MAX_NUM_LANES-1:0]     active_lanes_i,
   input  logic [MAX_NUM_LANES-1:0]     ts_valid_i,
   input  logic [MAX_NUM_LANES-1:0]     ts_type_i,
   input  logic [8*MAX_NUM_LANES-1:0]   ts_link_num_i,
   input  logic [8*MAX_NUM_LANES-1:0]   ts_lane_num_i,
   input  logic [MAX_NUM_LANES-1:0]     idle_valid_i,
   output logic [MAX_NUM_LANES-1:0]     lanes_ts1_satisfied_o,
   output logic [MAX_NUM_LANES-1:0]     lanes_ts2_satisfied_o,
   output logic [MAX_NUM_LANES-1:0]     config_complete_ts2_o,
   output logic                         link_lanes_formed_o,
   output logic                         link_lanes_nums_match_o,
   output logic                         single_idle_recieved_o,
   output logic                         link_idle_satisfied_o
);
   localparam int N = MAX_NUM_LANES;
   localparam int IW = $clog2(IDLE_COUNT_TARGET + 1);
   localparam logic [3:0] TS_T = 4'(TS_COUNT_TARGET);
   localparam logic [IW-1:0] IDLE_T = IW'(IDLE_COUNT_TARGET);

   logic [N-1:0]          typ;
   logic [N-1:0][7:0]     link;
   logic [N-1:0][7:0]     lane;
   logic [N-1:0][3:0]     ts_cnt;
   logic [N-1:0][IW-1:0]  idle_cnt;
   logic                  idle_seen;
   logic [N-1:0]          sat1, sat2, cc, lane_ok, num_ok, idle_ok;
   logic [7:0]            ref_link;

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         typ       <= '0;
         link      <= '0;
         lane      <= '0;
         ts_cnt    <= '0;
         idle_cnt  <= '0;
         idle_seen <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!active_lanes_i[i]) begin
               ts_cnt[i]   <= '0;
               idle_cnt[i] <= '0;
            end else if (ts_valid_i[i]) begin
               if (typ[i] == ts_type_i[i] && link[i] == ts_link_num_i[8*i +: 8] &&
                   lane[i] == ts_lane_num_i[8*i +: 8])
                  ts_cnt[i] <= (ts_cnt[i] == TS_T) ? ts_cnt[i] : ts_cnt[i] + 4'd1;
               else begin
                  typ[i]    <= ts_type_i[i];
                  link[i]   <= ts_link_num_i[8*i +: 8];
                  lane[i]   <= ts_lane_num_i[8*i +: 8];
                  ts_cnt[i] <= 4'd1;
               end
               idle_cnt[i] <= '0;
            end else if (idle_valid_i[i] && idle_cnt[i] != IDLE_T)
               idle_cnt[i] <= idle_cnt[i] + 1'b1;
         end
         if (|(active_lanes_i & idle_valid_i & ~ts_valid_i))
            idle_seen <= 1'b1;
      end
   end

   // reference link comes from the lowest-indexed active lane
   always_comb begin
      ref_link = '0;
      sat1 = '0;
      sat2 = '0;
      cc = '0;
      lane_ok = '0;
      num_ok = '0;
      idle_ok = '0;
      for (int i = N - 1; i >= 0; i--)
         ref_link = active_lanes_i[i] ? link[i] : ref_link;
      for (int i = 0; i < N; i++) begin
         sat1[i]    = active_lanes_i[i] && ts_cnt[i] == TS_T && !typ[i];
         sat2[i]    = active_lanes_i[i] && ts_cnt[i] == TS_T && typ[i];
         cc[i]      = sat2[i] && link[i] != PAD_SYMBOL && lane[i] != PAD_SYMBOL && link[i] == ref_link;
         lane_ok[i] = !active_lanes_i[i] || ((sat1[i] || sat2[i]) && link[i] != PAD_SYMBOL && link[i] == ref_link);
         num_ok[i]  = !active_lanes_i[i] || lane[i] == 8'(i);
         idle_ok[i] = !active_lanes_i[i] || idle_cnt[i] == IDLE_T;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         lanes_ts1_satisfied_o   <= '0;
         lanes_ts2_satisfied_o   <= '0;
         config_complete_ts2_o   <= '0;
         link_lanes_formed_o     <= 1'b0;
         link_lanes_nums_match_o <= 1'b0;
         single_idle_recieved_o  <= 1'b0;
         link_idle_satisfied_o   <= 1'b0;
      end else begin
         lanes_ts1_satisfied_o   <= sat1;
         lanes_ts2_satisfied_o   <= sat2;
         config_complete_ts2_o   <= cc;
         link_lanes_formed_o     <= |active_lanes_i && &lane_ok;
         link_lanes_nums_match_o <= |active_lanes_i && &lane_ok && &num_ok;
         single_idle_recieved_o  <= idle_seen;
         link_idle_satisfied_o   <= |active_lanes_i && &idle_ok;
      end
   end
endmodule
